label_scheduler: RTL and testbench

LABEL_SCHEDULER -- requirements
Module: label_scheduler

---
 rtl/label_scheduler_if.sv | 28 ++
 rtl/label_scheduler.sv | 124 ++++++++++++
 tb/tb_label_scheduler.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/label_scheduler_if.sv
// Handshake bundle between a score producer/result consumer (master)
// and the label scheduler (slave).
interface label_scheduler_if #(
    parameter int N       = 8,
    parameter int LABEL_W = 4
);
    logic               start;
    logic               in_valid;
    logic [N-1:0]       in_data;
    logic               in_last;
    logic               in_ready;
    logic               out_valid;
    logic [LABEL_W-1:0] out_label;
    logic [N-1:0]       out_score;
    logic               out_err;
    logic               out_ready;
    logic               busy;

    modport master (
        output start, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_label, out_score, out_err, busy
    );

    modport slave (
        input  start, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_label, out_score, out_err, busy
    );
endinterface

// File: rtl/label_scheduler.sv
// Collects NUM_LABELS unsigned scores per frame and reports the arg-max
// label and score, plus a flag when in_last disagrees with the frame length.
module label_scheduler #(
    parameter int N          = 8,
    parameter int NUM_LABELS = 10,
    parameter int LABEL_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    label_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [LABEL_W-1:0] LAST_IDX = LABEL_W'(NUM_LABELS - 1);

    state_t             r_state;
    state_t             w_nextState;
    logic [LABEL_W-1:0] r_idx;
    logic [LABEL_W-1:0] r_maxIdx;
    logic [N-1:0]       r_maxVal;
    logic               r_err;
    logic [LABEL_W-1:0] r_outLabel;
    logic [N-1:0]       r_outScore;
    logic               r_outErr;

    logic               w_inReady;
    logic               w_outValid;
    logic               w_busy;
    logic               w_accept;
    logic               w_isLast;
    logic               w_take;
    logic               w_errNow;
    logic [N-1:0]       w_newMax;
    logic [LABEL_W-1:0] w_newIdx;

    // Index 0 always loads, so stale max_val never leaks into a new frame;
    // strict compare keeps the lowest index on ties.
    assign w_isLast = (r_idx == LAST_IDX);
    assign w_take   = (r_idx == '0) || (bus.in_data > r_maxVal);
    assign w_newMax = w_take ? bus.in_data : r_maxVal;
    assign w_newIdx = w_take ? r_idx : r_maxIdx;
    assign w_errNow = r_err | (bus.in_last ^ w_isLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_inReady   = 1'b0;
        w_outValid  = 1'b0;
        w_busy      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_nextState = COLLECT;
                end
            end
            COLLECT: begin
                w_inReady = 1'b1;
                w_busy    = 1'b1;
                w_accept  = bus.in_valid;
                if (w_accept && w_isLast) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_outValid = 1'b1;
                w_busy     = 1'b1;
                if (bus.out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Result registers load only on the final accept, so they hold steady
    // through DONE and keep their value afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_maxIdx   <= '0;
            r_maxVal   <= '0;
            r_err      <= 1'b0;
            r_outLabel <= '0;
            r_outScore <= '0;
            r_outErr   <= 1'b0;
        end else if (r_state == IDLE && bus.start) begin
            r_idx    <= '0;
            r_maxIdx <= '0;
            r_maxVal <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_idx    <= r_idx + LABEL_W'(1);
            r_maxVal <= w_newMax;
            r_maxIdx <= w_newIdx;
            r_err    <= w_errNow;
            if (w_isLast) begin
                r_outLabel <= w_newIdx;
                r_outScore <= w_newMax;
                r_outErr   <= w_errNow;
            end
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = w_outValid;
    assign bus.busy      = w_busy;
    assign bus.out_label = r_outLabel;
    assign bus.out_score = r_outScore;
    assign bus.out_err   = r_outErr;
endmodule

// File: tb/tb_label_scheduler.sv
// Self-checking bench for label_scheduler: table-driven frames plus
// hand-written back-pressure, reset-abort and start/valid corner sequences.
module tb_label_scheduler;
    localparam int N          = 8;
    localparam int NUM_LABELS = 10;
    localparam int LABEL_W    = 4;
    localparam int NUM_VECS   = 8;

    typedef logic [N-1:0] score_t;

    typedef struct {
        string                 name;
        score_t                scores [NUM_LABELS];
        logic [NUM_LABELS-1:0] lastMask;
        logic [LABEL_W-1:0]    expLabel;
        score_t                expScore;
        logic                  expErr;
    } vec_t;

    typedef struct {
        logic [LABEL_W-1:0] label;
        score_t             score;
        logic               err;
    } exp_t;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    int     total = 0;
    int     bad   = 0;
    exp_t   expQ[$];
    vec_t   vecs [NUM_VECS];
    score_t frame [NUM_LABELS];

    label_scheduler_if #(.N(N), .LABEL_W(LABEL_W)) bus ();

    label_scheduler #(
        .N(N),
        .NUM_LABELS(NUM_LABELS),
        .LABEL_W(LABEL_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushExp(input logic [LABEL_W-1:0] label, input score_t score,
                           input logic err);
        exp_t e;
        e.label = label;
        e.score = score;
        e.err   = err;
        expQ.push_back(e);
    endtask

    // Reference arg-max with lowest-index tie break, plus framing check.
    function automatic exp_t modelFrame(input score_t sc [NUM_LABELS],
                                        input logic [NUM_LABELS-1:0] m);
        exp_t e;
        e.label = '0;
        e.score = sc[0];
        e.err   = 1'b0;
        for (int i = 1; i < NUM_LABELS; i++) begin
            if (sc[i] > e.score) begin
                e.score = sc[i];
                e.label = LABEL_W'(i);
            end
        end
        for (int i = 0; i < NUM_LABELS; i++) begin
            if (m[i] != (i == NUM_LABELS - 1)) e.err = 1'b1;
        end
        return e;
    endfunction

    // Called at a negedge in IDLE; returns at the negedge after the final accept.
    task automatic applyStimulus(input score_t sc [NUM_LABELS],
                                 input logic [NUM_LABELS-1:0] lastMask,
                                 input int gapPct, input bit validWithStart,
                                 input bit startInCollect);
        int gaps;
        bus.start = 1'b1;
        if (validWithStart) begin
            bus.in_valid = 1'b1;
            bus.in_data  = '1;
            bus.in_last  = 1'b1;
        end
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        for (int i = 0; i < NUM_LABELS; i++) begin
            gaps = 0;
            while (gapPct > 0 && gaps < 3 && $urandom_range(99) < gapPct) begin
                bus.in_valid = 1'b0;
                bus.in_data  = score_t'($urandom);
                bus.start    = startInCollect;
                @(negedge clk);
                gaps++;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = sc[i];
            bus.in_last  = lastMask[i];
            bus.start    = startInCollect;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.start    = 1'b0;
    endtask

    task automatic checkResult(input string name, input bit handshake);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (expQ.size() == 0) begin
            checkOutput({name, " queue"}, 0, 1);
        end else begin
            e = expQ.pop_front();
            checkOutput({name, " out_valid"}, 32'(bus.out_valid), 1);
            checkOutput({name, " latency"}, cyc, 0);
            checkOutput({name, " label"}, 32'(bus.out_label), 32'(e.label));
            checkOutput({name, " score"}, 32'(bus.out_score), 32'(e.score));
            checkOutput({name, " err"}, 32'(bus.out_err), 32'(e.err));
        end
        if (handshake) begin
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
            checkOutput({name, " idle busy"}, 32'(bus.busy), 0);
            checkOutput({name, " idle out_valid"}, 32'(bus.out_valid), 0);
        end
    endtask

    initial begin
        exp_t rnd;
        logic [NUM_LABELS-1:0] mask;

        vecs[0].name = "basic";
        vecs[0].scores = '{8'd3, 8'd9, 8'd1, 8'd200, 8'd7, 8'd0, 8'd5, 8'd199, 8'd2, 8'd4};
        vecs[0].lastMask = 10'b10_0000_0000;
        vecs[0].expLabel = 4'd3; vecs[0].expScore = 8'd200; vecs[0].expErr = 1'b0;

        vecs[1].name = "tie";
        vecs[1].scores = '{8'd10, 8'd10, 8'd50, 8'd10, 8'd10, 8'd10, 8'd50, 8'd10, 8'd10, 8'd10};
        vecs[1].lastMask = 10'b10_0000_0000;
        vecs[1].expLabel = 4'd2; vecs[1].expScore = 8'd50; vecs[1].expErr = 1'b0;

        vecs[2].name = "early_last";
        vecs[2].scores = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
        vecs[2].lastMask = 10'b10_0001_0000;
        vecs[2].expLabel = 4'd9; vecs[2].expScore = 8'd10; vecs[2].expErr = 1'b1;

        vecs[3].name = "missing_last";
        vecs[3].scores = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        vecs[3].lastMask = 10'b00_0000_0000;
        vecs[3].expLabel = 4'd0; vecs[3].expScore = 8'd9; vecs[3].expErr = 1'b1;

        vecs[4].name = "all_max";
        vecs[4].scores = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        vecs[4].lastMask = 10'b10_0000_0000;
        vecs[4].expLabel = 4'd0; vecs[4].expScore = 8'd255; vecs[4].expErr = 1'b0;

        vecs[5].name = "only_last";
        vecs[5].scores = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
        vecs[5].lastMask = 10'b10_0000_0000;
        vecs[5].expLabel = 4'd9; vecs[5].expScore = 8'd1; vecs[5].expErr = 1'b0;

        vecs[6].name = "first_vs_last_tie";
        vecs[6].scores = '{8'd128, 8'd0, 8'd127, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd128};
        vecs[6].lastMask = 10'b10_0000_0000;
        vecs[6].expLabel = 4'd0; vecs[6].expScore = 8'd128; vecs[6].expErr = 1'b0;

        vecs[7].name = "late_max_high_bit";
        vecs[7].scores = '{8'd127, 8'd100, 8'd126, 8'd3, 8'd90, 8'd60, 8'd30, 8'd128, 8'd127, 8'd5};
        vecs[7].lastMask = 10'b10_0000_0000;
        vecs[7].expLabel = 4'd7; vecs[7].expScore = 8'd128; vecs[7].expErr = 1'b0;

        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset in_ready", 32'(bus.in_ready), 0);
        checkOutput("reset out_valid", 32'(bus.out_valid), 0);
        checkOutput("reset busy", 32'(bus.busy), 0);
        checkOutput("reset out_label", 32'(bus.out_label), 0);
        checkOutput("reset out_score", 32'(bus.out_score), 0);
        checkOutput("reset out_err", 32'(bus.out_err), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post-reset busy", 32'(bus.busy), 0);

        // Table frames run back to back: next start one cycle after handshake.
        for (int v = 0; v < NUM_VECS; v++) begin
            pushExp(vecs[v].expLabel, vecs[v].expScore, vecs[v].expErr);
            applyStimulus(vecs[v].scores, vecs[v].lastMask, 0, 1'b0, 1'b0);
            checkResult(vecs[v].name, 1'b1);
        end

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NUM_LABELS; i++) frame[i] = score_t'($urandom);
            mask = (r == 3) ? NUM_LABELS'($urandom) : 10'b10_0000_0000;
            rnd = modelFrame(frame, mask);
            pushExp(rnd.label, rnd.score, rnd.err);
            applyStimulus(frame, mask, 40, 1'b0, 1'b0);
            checkResult("random_gaps", 1'b1);
        end

        for (int i = 0; i < NUM_LABELS; i++) frame[i] = 8'd1;
        frame[5] = 8'd7;
        pushExp(4'd5, 8'd7, 1'b0);
        applyStimulus(frame, 10'b10_0000_0000, 0, 1'b1, 1'b0);
        checkResult("valid_with_start", 1'b1);

        // Back-pressure with start held high throughout COLLECT and DONE.
        frame = '{8'd20, 8'd30, 8'd40, 8'd90, 8'd90, 8'd10, 8'd0, 8'd89, 8'd2, 8'd1};
        pushExp(4'd3, 8'd90, 1'b0);
        applyStimulus(frame, 10'b10_0000_0000, 50, 1'b0, 1'b1);
        checkResult("backpressure", 1'b0);
        bus.start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("hold out_valid", 32'(bus.out_valid), 1);
            checkOutput("hold label", 32'(bus.out_label), 3);
            checkOutput("hold score", 32'(bus.out_score), 90);
            checkOutput("hold err", 32'(bus.out_err), 0);
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput("release out_valid", 32'(bus.out_valid), 0);
        checkOutput("release busy", 32'(bus.busy), 0);
        checkOutput("idle keeps label", 32'(bus.out_label), 3);
        checkOutput("idle keeps score", 32'(bus.out_score), 90);
        @(negedge clk);
        checkOutput("idle stays idle", 32'(bus.busy), 0);

        // Reset asserted mid-COLLECT with idx at 5.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("collect in_ready", 32'(bus.in_ready), 1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(100 + i);
            @(negedge clk);
        end
        bus.in_data = 8'd77;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort in_ready", 32'(bus.in_ready), 0);
        checkOutput("abort busy", 32'(bus.busy), 0);
        checkOutput("abort out_valid", 32'(bus.out_valid), 0);
        checkOutput("abort out_label", 32'(bus.out_label), 0);
        checkOutput("abort out_score", 32'(bus.out_score), 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("after abort busy", 32'(bus.busy), 0);
        checkOutput("after abort out_valid", 32'(bus.out_valid), 0);

        for (int i = 0; i < NUM_LABELS; i++) frame[i] = 8'd0;
        pushExp(4'd0, 8'd0, 1'b0);
        applyStimulus(frame, 10'b10_0000_0000, 0, 1'b0, 1'b0);
        checkResult("zeros_after_reset", 1'b1);

        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
